// File: rtl/idli_spc_m.sv
// idli_spc_m: bit-serial program counter for the idli core.
// The PC rotates SLICE bits per cycle, LSB slice first, and completes one
// update (hold, increment, PC-relative add or absolute load) every
// WIDTH/SLICE cycles. It also produces a serial PC + step link value for
// calls and reports the carry-out of the previous update.
module idli_spc_m #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   localparam int N  = WIDTH / SLICE,
   localparam int CW = (N > 1) ? $clog2(N) : 1
) (
   input  logic             i_spc_gck,
   input  logic             i_spc_rst,
   input  logic [1:0]       i_spc_mode,
   input  logic [1:0]       i_spc_step,
   input  logic [SLICE-1:0] i_spc_data,
   output logic [SLICE-1:0] o_spc,
   output logic [SLICE-1:0] o_spc_next,
   output logic [SLICE-1:0] o_spc_link,
   output logic [CW-1:0]    o_spc_ctr,
   output logic             o_spc_first,
   output logic             o_spc_last,
   output logic             o_spc_wrap
);

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_INC  = 2'b01,
      MODE_REL  = 2'b10,
      MODE_ABS  = 2'b11
   } mode_t;

   logic [WIDTH-1:0] pc_q;
   logic [CW-1:0]    ctr_q;
   logic             carry_q;
   logic             lcarry_q;
   mode_t            mode_q;
   logic [1:0]       step_q;
   logic             wrap_q;

   logic             first;
   logic             last;
   mode_t            eff_mode;
   logic [1:0]       eff_step;
   logic             cin;
   logic             lcin;
   logic [SLICE-1:0] addend;
   logic             add_en;
   logic [SLICE:0]   sum_full;
   logic [SLICE:0]   link_full;
   logic [SLICE-1:0] link_addend;
   logic             cout;
   logic             lcout;

   // Slice position and the controls that apply to this slice: the live
   // inputs on the first slice, the latched copies on every later slice.
   assign first    = (ctr_q == '0);
   assign last     = (ctr_q == CW'(N - 1));
   assign eff_mode = first ? mode_t'(i_spc_mode) : mode_q;
   assign eff_step = first ? i_spc_step : step_q;
   assign cin      = first ? 1'b0 : carry_q;
   assign lcin     = first ? 1'b0 : lcarry_q;

   // Select what gets added to the current slice for the active update mode.
   always_comb begin
      addend = '0;
      add_en = 1'b0;
      case (eff_mode)
         MODE_INC: begin
            addend = first ? SLICE'(eff_step) : '0;
            add_en = 1'b1;
         end
         MODE_REL: begin
            addend = i_spc_data;
            add_en = 1'b1;
         end
         default: begin
            addend = '0;
            add_en = 1'b0;
         end
      endcase
   end

   assign sum_full = {1'b0, o_spc} + {1'b0, addend} + {{SLICE{1'b0}}, cin};
   assign cout     = add_en & sum_full[SLICE];

   // Choose the slice written back into the PC for the active update mode.
   always_comb begin
      o_spc_next = sum_full[SLICE-1:0];
      case (eff_mode)
         MODE_HOLD: o_spc_next = o_spc;
         MODE_ABS:  o_spc_next = i_spc_data;
         default:   o_spc_next = sum_full[SLICE-1:0];
      endcase
   end

   // The link adder always computes PC + step, independent of the mode.
   assign link_addend = first ? SLICE'(eff_step) : '0;
   assign link_full   = {1'b0, o_spc} + {1'b0, link_addend} + {{SLICE{1'b0}}, lcin};
   assign lcout       = link_full[SLICE];
   assign o_spc_link  = link_full[SLICE-1:0];

   assign o_spc       = pc_q[SLICE-1:0];
   assign o_spc_ctr   = ctr_q;
   assign o_spc_first = first;
   assign o_spc_last  = last;
   assign o_spc_wrap  = wrap_q;

   // Rotate the PC, advance the slice counter, carry both adders between
   // slices and capture the update carry-out as wrap on the last slice.
   always_ff @(posedge i_spc_gck) begin
      if (i_spc_rst) begin
         pc_q     <= RESET_PC;
         ctr_q    <= '0;
         carry_q  <= 1'b0;
         lcarry_q <= 1'b0;
         mode_q   <= MODE_HOLD;
         step_q   <= '0;
         wrap_q   <= 1'b0;
      end else begin
         ctr_q    <= last ? '0 : ctr_q + CW'(1);
         carry_q  <= cout;
         lcarry_q <= lcout;
         pc_q     <= {o_spc_next, pc_q[WIDTH-1:SLICE]};
         if (first) begin
            mode_q <= mode_t'(i_spc_mode);
            step_q <= i_spc_step;
         end
         if (last) begin
            wrap_q <= cout;
         end
      end
   end

endmodule

// File: tb/tb_idli_spc_m.sv
// Self-checking bench for idli_spc_m. A whole-word reference model predicts
// each update from full-width arithmetic and is compared slice by slice.
module tb_idli_spc_m;

   localparam int WIDTH = 16;
   localparam int SLICE = 4;
   localparam int N     = WIDTH / SLICE;
   localparam int CW    = $clog2(N);
   localparam logic [WIDTH-1:0] RESET_PC = 16'h0000;

   localparam logic [1:0] HOLD = 2'b00;
   localparam logic [1:0] INC  = 2'b01;
   localparam logic [1:0] REL  = 2'b10;
   localparam logic [1:0] ABS  = 2'b11;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       mode_in;
   logic [1:0]       step_in;
   logic [SLICE-1:0] data_in;
   logic [SLICE-1:0] o_spc;
   logic [SLICE-1:0] o_spc_next;
   logic [SLICE-1:0] o_spc_link;
   logic [CW-1:0]    o_spc_ctr;
   logic             o_spc_first;
   logic             o_spc_last;
   logic             o_spc_wrap;

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] m_pc;
   logic             m_wrap;

   idli_spc_m #(
      .WIDTH(WIDTH),
      .SLICE(SLICE),
      .RESET_PC(RESET_PC)
   ) dut (
      .i_spc_gck(clk),
      .i_spc_rst(rst),
      .i_spc_mode(mode_in),
      .i_spc_step(step_in),
      .i_spc_data(data_in),
      .o_spc(o_spc),
      .o_spc_next(o_spc_next),
      .o_spc_link(o_spc_link),
      .o_spc_ctr(o_spc_ctr),
      .o_spc_first(o_spc_first),
      .o_spc_last(o_spc_last),
      .o_spc_wrap(o_spc_wrap)
   );

   // Free-running core clock.
   always #5 clk = ~clk;

   // One comparison: count it, and report it if the observed value differs.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one complete update and check every slice against the model.
   // other_mode is driven on the non-first slices, where it must be ignored.
   task automatic applyStimulus(input string tag, input logic [1:0] mode, input logic [1:0] step,
                                input logic [WIDTH-1:0] data, input logic [1:0] other_mode);
      logic [WIDTH:0]   full;
      logic [WIDTH-1:0] new_pc;
      logic [WIDTH-1:0] link;
      logic             new_wrap;
      link = m_pc + WIDTH'(step);
      case (mode)
         HOLD: begin
            new_pc   = m_pc;
            new_wrap = 1'b0;
         end
         INC: begin
            full     = {1'b0, m_pc} + (WIDTH+1)'(step);
            new_pc   = full[WIDTH-1:0];
            new_wrap = full[WIDTH];
         end
         REL: begin
            full     = {1'b0, m_pc} + {1'b0, data};
            new_pc   = full[WIDTH-1:0];
            new_wrap = full[WIDTH];
         end
         default: begin
            new_pc   = data;
            new_wrap = 1'b0;
         end
      endcase
      for (int j = 0; j < N; j++) begin
         @(negedge clk);
         mode_in = (j == 0) ? mode : other_mode;
         step_in = (j == 0) ? step : 2'($urandom);
         data_in = data[j*SLICE +: SLICE];
         #1;
         checkOutput($sformatf("%s pc[%0d]", tag, j), o_spc, m_pc[j*SLICE +: SLICE]);
         checkOutput($sformatf("%s next[%0d]", tag, j), o_spc_next, new_pc[j*SLICE +: SLICE]);
         checkOutput($sformatf("%s link[%0d]", tag, j), o_spc_link, link[j*SLICE +: SLICE]);
         checkOutput($sformatf("%s ctr[%0d]", tag, j), o_spc_ctr, j);
         checkOutput($sformatf("%s first[%0d]", tag, j), o_spc_first, (j == 0));
         checkOutput($sformatf("%s last[%0d]", tag, j), o_spc_last, (j == N - 1));
         checkOutput($sformatf("%s wrap[%0d]", tag, j), o_spc_wrap, m_wrap);
      end
      m_pc   = new_pc;
      m_wrap = new_wrap;
   endtask

   // Check the outputs that must hold on the cycle right after a reset.
   task automatic checkResetState(input string tag);
      checkOutput({tag, " pc"}, o_spc, RESET_PC[SLICE-1:0]);
      checkOutput({tag, " ctr"}, o_spc_ctr, 0);
      checkOutput({tag, " first"}, o_spc_first, 1);
      checkOutput({tag, " last"}, o_spc_last, 0);
      checkOutput({tag, " wrap"}, o_spc_wrap, 0);
   endtask

   // Start an INC update, then reset on the third slice to abandon it.
   task automatic resetMidUpdate();
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         mode_in = INC;
         step_in = 2'd1;
         data_in = SLICE'($urandom);
         #1;
         checkOutput($sformatf("midrst ctr[%0d]", j), o_spc_ctr, j);
         checkOutput($sformatf("midrst wrap[%0d]", j), o_spc_wrap, m_wrap);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      m_pc   = RESET_PC;
      m_wrap = 1'b0;
      checkResetState("midrst after");
   endtask

   // Directed scenarios first, then randomized updates against the model.
   initial begin
      rst     = 1'b1;
      mode_in = HOLD;
      step_in = 2'd0;
      data_in = '0;
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      m_pc   = RESET_PC;
      m_wrap = 1'b0;
      checkResetState("reset");

      applyStimulus("hold0", HOLD, 2'd0, 16'h0000, HOLD);
      applyStimulus("hold1", HOLD, 2'd3, 16'hBEEF, INC);

      applyStimulus("ld00ff", ABS, 2'd0, 16'h00FF, HOLD);
      applyStimulus("inc1", INC, 2'd1, 16'h5A5A, REL);
      applyStimulus("chk0100", HOLD, 2'd0, 16'h0000, HOLD);

      applyStimulus("ldffff", ABS, 2'd0, 16'hFFFF, HOLD);
      applyStimulus("inc2", INC, 2'd2, 16'h0000, ABS);
      applyStimulus("wrapheld", HOLD, 2'd0, 16'h0000, INC);
      applyStimulus("wrapclr", HOLD, 2'd0, 16'h0000, HOLD);

      applyStimulus("ld0010", ABS, 2'd0, 16'h0010, HOLD);
      applyStimulus("relneg", REL, 2'd1, 16'hFFFE, HOLD);
      applyStimulus("chk000e", HOLD, 2'd0, 16'h0000, HOLD);

      applyStimulus("ld0000", ABS, 2'd0, 16'h0000, HOLD);
      applyStimulus("lateabs", HOLD, 2'd0, 16'h1234, ABS);
      applyStimulus("abs1234", ABS, 2'd0, 16'h1234, HOLD);
      applyStimulus("chk1234", HOLD, 2'd0, 16'h0000, HOLD);

      applyStimulus("ld0102", ABS, 2'd0, 16'h0102, HOLD);
      applyStimulus("rel0100", REL, 2'd0, 16'hFFFE, HOLD);
      resetMidUpdate();
      applyStimulus("postrst", HOLD, 2'd0, 16'h0000, HOLD);

      for (int k = 0; k < 40; k++) begin
         applyStimulus($sformatf("rnd%0d", k), 2'($urandom), 2'($urandom),
                       16'($urandom), 2'($urandom));
      end

      $display("[TB] all scenarios complete");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
